// File: rtl/nastilite_master_if.sv
// NASTI-Lite bus bundle shared by the initiator and the register slave.
// Channel payload widths follow the address/data parameters.
interface nasti_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              b_valid;
  logic              b_ready;
  logic [1:0]        b_resp;
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  modport master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/nastilite_master.sv
// Single-outstanding NASTI-Lite initiator: turns one command into one bus
// write or read and returns the slave's response code and read data.
module nastilite_master #(
  parameter int unsigned C_NASTI_ADDR_WIDTH = 5,
  parameter int unsigned C_NASTI_DATA_WIDTH = 64
) (
  input  logic                            m_nastilite_clk,
  input  logic                            m_nastilite_reset,
  nasti_if.master                         m_nastilite,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_NASTI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_NASTI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_NASTI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [1:0]                      rsp_resp,
  output logic [C_NASTI_DATA_WIDTH-1:0]   rsp_rdata
);

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

  state_t state;
  logic   aw_done_c;
  logic   w_done_c;

  assign cmd_ready = (state == IDLE) && !m_nastilite_reset;

  // A channel is finished if it already handshook or handshakes at this edge.
  assign aw_done_c = !m_nastilite.aw_valid || m_nastilite.aw_ready;
  assign w_done_c  = !m_nastilite.w_valid  || m_nastilite.w_ready;

  always_ff @(posedge m_nastilite_clk) begin
    if (m_nastilite_reset) begin
      state               <= IDLE;
      m_nastilite.aw_valid <= 1'b0;
      m_nastilite.aw_addr  <= '0;
      m_nastilite.w_valid  <= 1'b0;
      m_nastilite.w_data   <= '0;
      m_nastilite.w_strb   <= '0;
      m_nastilite.b_ready  <= 1'b0;
      m_nastilite.ar_valid <= 1'b0;
      m_nastilite.ar_addr  <= '0;
      m_nastilite.r_ready  <= 1'b0;
      rsp_valid           <= 1'b0;
      rsp_write           <= 1'b0;
      rsp_resp            <= '0;
      rsp_rdata           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              m_nastilite.aw_valid <= 1'b1;
              m_nastilite.aw_addr  <= cmd_addr;
              m_nastilite.w_valid  <= 1'b1;
              m_nastilite.w_data   <= cmd_wdata;
              m_nastilite.w_strb   <= cmd_wstrb;
              state               <= WR;
            end else begin
              m_nastilite.ar_valid <= 1'b1;
              m_nastilite.ar_addr  <= cmd_addr;
              state               <= RA;
            end
          end
        end

        WR: begin
          if (m_nastilite.aw_valid && m_nastilite.aw_ready) m_nastilite.aw_valid <= 1'b0;
          if (m_nastilite.w_valid && m_nastilite.w_ready)   m_nastilite.w_valid  <= 1'b0;
          if (aw_done_c && w_done_c) begin
            m_nastilite.b_ready <= 1'b1;
            state              <= WB;
          end
        end

        WB: begin
          if (m_nastilite.b_valid) begin
            m_nastilite.b_ready <= 1'b0;
            rsp_valid          <= 1'b1;
            rsp_write          <= 1'b1;
            rsp_resp           <= m_nastilite.b_resp;
            rsp_rdata          <= '0;
            state              <= RSP;
          end
        end

        RA: begin
          if (m_nastilite.ar_ready) begin
            m_nastilite.ar_valid <= 1'b0;
            m_nastilite.r_ready  <= 1'b1;
            state               <= RD;
          end
        end

        // r_ready is low in RA, so an early r_valid is only taken from here.
        RD: begin
          if (m_nastilite.r_valid) begin
            m_nastilite.r_ready <= 1'b0;
            rsp_valid          <= 1'b1;
            rsp_write          <= 1'b0;
            rsp_resp           <= m_nastilite.r_resp;
            rsp_rdata          <= m_nastilite.r_data;
            state              <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nastilite_master.sv
// Bench for nastilite_master: configurable-delay slave model, bus/response
// scoreboards, and one task per scenario.
module tb_nastilite_master;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [1:0]    rsp_resp;
  logic [DW-1:0] rsp_rdata;

  always #5 clk = ~clk;

  nasti_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  nastilite_master #(.C_NASTI_ADDR_WIDTH(AW), .C_NASTI_DATA_WIDTH(DW)) dut (
    .m_nastilite_clk   (clk),
    .m_nastilite_reset (rst),
    .m_nastilite       (bus),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_addr          (cmd_addr),
    .cmd_wdata         (cmd_wdata),
    .cmd_wstrb         (cmd_wstrb),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_write         (rsp_write),
    .rsp_resp          (rsp_resp),
    .rsp_rdata         (rsp_rdata)
  );

  // ---------------- slave model ----------------
  int            aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int            aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic          b_stall = 1'b0;
  logic [1:0]    slv_bresp = 2'b00;
  logic [1:0]    slv_rresp = 2'b00;
  logic [DW-1:0] slv_rdata = '0;

  always @(posedge clk) begin
    aw_cnt <= (bus.aw_valid && !bus.aw_ready) ? aw_cnt + 1 : 0;
    w_cnt  <= (bus.w_valid  && !bus.w_ready)  ? w_cnt + 1  : 0;
    b_cnt  <= (bus.b_ready  && !bus.b_valid)  ? b_cnt + 1  : 0;
    ar_cnt <= (bus.ar_valid && !bus.ar_ready) ? ar_cnt + 1 : 0;
    r_cnt  <= (bus.r_ready  && !bus.r_valid)  ? r_cnt + 1  : 0;
  end

  assign bus.aw_ready = bus.aw_valid && (aw_cnt >= aw_dly);
  assign bus.w_ready  = bus.w_valid  && (w_cnt  >= w_dly);
  assign bus.b_valid  = bus.b_ready  && !b_stall && (b_cnt >= b_dly);
  assign bus.b_resp   = slv_bresp;
  assign bus.ar_ready = bus.ar_valid && (ar_cnt >= ar_dly);
  assign bus.r_valid  = bus.r_ready  && (r_cnt  >= r_dly);
  assign bus.r_resp   = slv_rresp;
  assign bus.r_data   = slv_rdata;

  // ---------------- scoreboards and monitor ----------------
  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } bus_t;

  typedef struct {
    logic          write;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t exp_q[$];
  bus_t mon_b;
  rsp_t mon_r;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_edge = 0, aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0;
  int b_first = 0, rsp_first = 0, rsp_hs_edge = 0;
  int aw_hi = 0, w_hi = 0, txn_cnt = 0, rsp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge numbers recorded here are the posedge that samples the signal.
  always @(negedge clk) begin
    if (!rst) begin
      mon_b = (bus_q.size() != 0) ? bus_q[0] : '{default: 'x};
      if (cmd_valid && cmd_ready) begin
        acc_edge = cyc + 1;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0;
        b_first = 0; rsp_first = 0; aw_hi = 0; w_hi = 0;
      end
      if (bus.aw_valid) begin
        aw_hi++;
        checks++;
        if ({1'b1, bus.aw_addr} !== {mon_b.write, mon_b.addr}) begin
          errors++;
          $display("FAIL aw_addr got %h exp %h (write=%b)", bus.aw_addr, mon_b.addr, mon_b.write);
        end
        if (bus.aw_ready) aw_hs = cyc + 1;
      end
      if (bus.w_valid) begin
        w_hi++;
        checks++;
        if ({1'b1, bus.w_data, bus.w_strb} !== {mon_b.write, mon_b.data, mon_b.strb}) begin
          errors++;
          $display("FAIL w_data got %h/%h exp %h/%h", bus.w_data, bus.w_strb, mon_b.data, mon_b.strb);
        end
        if (bus.w_ready) w_hs = cyc + 1;
      end
      if (bus.ar_valid) begin
        checks++;
        if ({1'b0, bus.ar_addr} !== {mon_b.write, mon_b.addr}) begin
          errors++;
          $display("FAIL ar_addr got %h exp %h (write=%b)", bus.ar_addr, mon_b.addr, mon_b.write);
        end
        if (bus.ar_ready) ar_hs = cyc + 1;
      end
      if (bus.b_ready) begin
        if (b_first == 0) b_first = cyc + 1;
        checks++;
        if (bus.aw_valid || bus.w_valid) begin
          errors++;
          $display("FAIL b_ready_early got aw_valid=%b w_valid=%b exp 0/0", bus.aw_valid, bus.w_valid);
        end
      end
      if ((bus.aw_valid || bus.w_valid || bus.b_ready) && (bus.ar_valid || bus.r_ready)) begin
        errors++;
        $display("FAIL overlap got write and read channels active together exp exclusive");
      end
      if ((bus.b_valid && bus.b_ready) || (bus.r_valid && bus.r_ready)) begin
        if (bus.b_valid) b_hs = cyc + 1;
        if (bus_q.size() != 0) void'(bus_q.pop_front());
        txn_cnt++;
      end
      if (rsp_valid && rsp_first == 0) rsp_first = cyc + 1;
      if (rsp_valid && rsp_ready) begin
        mon_r = (exp_q.size() != 0) ? exp_q.pop_front() : '{default: 'x};
        checks++;
        if ({rsp_write, rsp_resp, rsp_rdata} !== {mon_r.write, mon_r.resp, mon_r.rdata}) begin
          errors++;
          $display("FAIL rsp got w=%b resp=%b data=%h exp w=%b resp=%b data=%h",
                   rsp_write, rsp_resp, rsp_rdata, mon_r.write, mon_r.resp, mon_r.rdata);
        end
        rsp_cnt++;
        rsp_hs_edge = cyc + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_cmd(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    bus_q.push_back('{write: w, addr: a, data: d, strb: s});
    exp_q.push_back('{write: w, resp: (w ? slv_bresp : slv_rresp), rdata: (w ? '0 : slv_rdata)});
  endtask

  task automatic wait_accept(input string tag);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL %s_accept got no cmd handshake exp handshake within 50 cycles", tag);
    end
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [SW-1:0] s, input string tag);
    load_cmd(w, a, d, s);
    cmd_valid = 1'b1;
    wait_accept(tag);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    logic hs;
    hs = 1'b0;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk);
      hs = rsp_valid && rsp_ready;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL %s_rsp got no response exp response within 100 cycles", tag);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready, rsp_valid,
         bus.aw_addr, bus.w_data, bus.w_strb, bus.ar_addr, rsp_write, rsp_resp, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero output exp all zero (cmd_ready=%b rsp_valid=%b)",
               cmd_ready, rsp_valid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release got cmd_ready=%b rsp_valid=%b exp 1/0", cmd_ready, rsp_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_basic();
    slv_bresp = 2'b00;
    send(1'b1, 5'h08, 64'h1122334455667788, 8'hFF, "wr_basic");
    wait_rsp("wr_basic");
    checks++;
    if ({aw_hs - acc_edge, w_hs - acc_edge, b_hs - acc_edge, rsp_first - acc_edge} !== {32'd1, 32'd1, 32'd2, 32'd3}) begin
      errors++;
      $display("FAIL wr_latency got aw=%0d w=%0d b=%0d rsp=%0d exp 1/1/2/3",
               aw_hs - acc_edge, w_hs - acc_edge, b_hs - acc_edge, rsp_first - acc_edge);
    end
  endtask

  task automatic test_write_order();
    aw_dly = 3; w_dly = 0;
    send(1'b1, 5'h10, 64'hA5A5_0000_FFFF_1234, 8'h3C, "wr_awslow");
    wait_rsp("wr_awslow");
    checks++;
    if ({aw_hi, w_hi, b_first - acc_edge, rsp_first - acc_edge} !== {32'd4, 32'd1, 32'd5, 32'd6}) begin
      errors++;
      $display("FAIL wr_awslow got aw_hi=%0d w_hi=%0d b_first=%0d rsp=%0d exp 4/1/5/6",
               aw_hi, w_hi, b_first - acc_edge, rsp_first - acc_edge);
    end
    aw_dly = 0; w_dly = 3;
    send(1'b1, 5'h14, 64'h0BAD_CAFE_DEAD_BEEF, 8'hC3, "wr_wslow");
    wait_rsp("wr_wslow");
    checks++;
    if ({aw_hi, w_hi, b_first - acc_edge, rsp_first - acc_edge} !== {32'd1, 32'd4, 32'd5, 32'd6}) begin
      errors++;
      $display("FAIL wr_wslow got aw_hi=%0d w_hi=%0d b_first=%0d rsp=%0d exp 1/4/5/6",
               aw_hi, w_hi, b_first - acc_edge, rsp_first - acc_edge);
    end
    w_dly = 0;
  endtask

  task automatic test_read_after_write();
    slv_rdata = 64'h1122334455667788;
    slv_rresp = 2'b10;
    send(1'b0, 5'h08, '0, '0, "rd");
    wait_rsp("rd");
    checks++;
    if ({ar_hs - acc_edge, rsp_first - acc_edge} !== {32'd1, 32'd3}) begin
      errors++;
      $display("FAIL rd_latency got ar=%0d rsp=%0d exp 1/3", ar_hs - acc_edge, rsp_first - acc_edge);
    end
    slv_rresp = 2'b00;
  endtask

  task automatic test_backpressure();
    logic          seen;
    logic [66:0]   snap;
    rsp_ready = 1'b0;
    slv_bresp = 2'b01;
    send(1'b1, 5'h18, 64'h0123_4567_89AB_CDEF, 8'h81, "bp_wr");
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_rsp_valid got 0 exp 1 within 20 cycles");
    end
    snap = {rsp_write, rsp_resp, rsp_rdata};
    checks++;
    if (snap !== {1'b1, 2'b01, 64'h0}) begin
      errors++;
      $display("FAIL bp_fields got %h exp %h", snap, {1'b1, 2'b01, 64'h0});
    end
    slv_rdata = 64'hFEED_FACE_0000_0042;
    load_cmd(1'b0, 5'h1C, '0, '0);
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready} !== {1'b1, snap, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold got valid=%b fields=%h cmd_ready=%b exp 1/%h/0",
                 rsp_valid, {rsp_write, rsp_resp, rsp_rdata}, cmd_ready, snap);
      end
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    wait_accept("bp_rd");
    cmd_valid = 1'b0;
    checks++;
    if (acc_edge - rsp_hs_edge !== 1) begin
      errors++;
      $display("FAIL bp_next_accept got %0d edges after rsp handshake exp 1", acc_edge - rsp_hs_edge);
    end
    wait_rsp("bp_rd");
    slv_bresp = 2'b00;
  endtask

  task automatic test_reset_in_wb();
    logic seen;
    int   base;
    b_stall = 1'b1;
    send(1'b1, 5'h04, 64'h5555_AAAA_5555_AAAA, 8'hFF, "rst_wr");
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.b_ready;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_wb_reach got b_ready=0 exp 1 within 10 cycles");
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready, rsp_valid,
         bus.aw_addr, bus.w_data, bus.w_strb, bus.ar_addr, rsp_write, rsp_resp, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL rst_wb_outputs got b_ready=%b aw_addr=%h w_data=%h exp all zero",
               bus.b_ready, bus.aw_addr, bus.w_data);
    end
    rst = 1'b0;
    b_stall = 1'b0;
    bus_q.delete();
    exp_q.delete();
    base = rsp_cnt;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wb_cmd_ready got %b exp 1", cmd_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, bus.b_ready} !== 2'b00) begin
        errors++;
        $display("FAIL rst_wb_abandon got rsp_valid=%b b_ready=%b exp 0/0", rsp_valid, bus.b_ready);
      end
    end
    checks++;
    if (rsp_cnt !== base) begin
      errors++;
      $display("FAIL rst_wb_rsp_count got %0d exp %0d", rsp_cnt, base);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic          w[3]  = '{1'b1, 1'b0, 1'b1};
    logic [AW-1:0] a[3]  = '{5'h00, 5'h08, 5'h1C};
    logic [DW-1:0] d[3]  = '{64'h0000_1111_2222_3333, 64'h0, 64'h4444_5555_6666_7777};
    logic [SW-1:0] s[3]  = '{8'h0F, 8'h00, 8'hF0};
    int            idx, base_txn, base_rsp;
    logic          acc;
    slv_rdata = 64'h9999_8888_7777_6666;
    base_txn = txn_cnt;
    base_rsp = rsp_cnt;
    idx = 0;
    load_cmd(w[0], a[0], d[0], s[0]);
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !(idx == 3 && rsp_cnt - base_rsp == 3); i++) begin
      @(negedge clk);
      acc = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) load_cmd(w[idx], a[idx], d[idx], s[idx]);
        else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if ({idx, txn_cnt - base_txn, rsp_cnt - base_rsp} !== {32'd3, 32'd3, 32'd3}) begin
      errors++;
      $display("FAIL b2b_counts got cmds=%0d txns=%0d rsps=%0d exp 3/3/3",
               idx, txn_cnt - base_txn, rsp_cnt - base_rsp);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_pending got %0d exp 0", exp_q.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_write_basic();
    test_write_order();
    test_read_after_write();
    test_backpressure();
    test_reset_in_wb();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion exp finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
